// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B-Bin subtractor with Start/Busy/Done handshake
// Optional: `define SERIAL_SUB_OVERFLOW_EN to build the signed-overflow flag.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Data_out_Diff,
    output logic             Data_out_Borrow,
    output logic             Data_out_Overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs
    assign w_a       = r_a_sr[0];
    assign w_b       = r_b_sr[0];
    assign w_d       = w_a ^ w_b ^ r_br;
    assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_accept  = Start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_res_next            = r_res_sr >> 1;
        w_res_next[WIDTH-1]   = w_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = w_accept ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = w_accept ? S_RUN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == S_RUN);
        Done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_diff   <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr   <= Data_in_A;
            r_b_sr   <= Data_in_B;
            r_br     <= Data_in_Bin;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= w_res_next;
            r_br     <= w_br_next;
            r_cnt    <= r_cnt + CW'(1);
            // Published outputs only move on the final bit so they hold during RUN
            if (w_last) begin
                r_diff   <= w_res_next;
                r_borrow <= w_br_next;
            end
        end
    end

    assign Data_out_Diff   = r_diff;
    assign Data_out_Borrow = r_borrow;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= Data_in_A[WIDTH-1];
            r_b_msb <= Data_in_B[WIDTH-1];
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign Data_out_Overflow = r_ovf;
`else
    assign Data_out_Overflow = 1'b0;
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor: the sequential, inverse-operation counterpart of the team's full-adder datapath cells. It computes A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is used in area-constrained arithmetic paths where a ripple array is too large, and it hands results to downstream logic with a Start/Busy/Done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled on a clk edge when state is IDLE or DONE
- Data_in_A  input  WIDTH  minuend, captured with Start
- Data_in_B  input  WIDTH  subtrahend, captured with Start
- Data_in_Bin  input  1  borrow-in, captured with Start
- Busy  output  1  high while state is RUN
- Done  output  1  one-cycle pulse; result valid
- Data_out_Diff  output  WIDTH  difference A − B − Bin mod 2^WIDTH
- Data_out_Borrow  output  1  final borrow-out (1 when A < B + Bin, unsigned)
- Data_out_Overflow  output  1  signed overflow flag (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE or DONE, Start=1: load A and B into shift registers, load the borrow FF with Bin, clear the bit counter, go to RUN.
- RUN, each cycle: a=A_sr[0], b=B_sr[0], br=borrow FF.
  - d = a^b^br
  - br_next = (~a&b) | (~(a^b)&br)
  - Shift d into the MSB of the result register (right shift). Shift A_sr and B_sr right.
  - Update the borrow FF and increment the counter.
- RUN, after the WIDTH-th bit: go to DONE. Diff, Borrow and Overflow update on this edge.
- DONE lasts one cycle, then goes to IDLE unless Start=1, which starts a new operation back-to-back.
- Start in RUN is ignored; inputs are not re-sampled.
- Data_out_Diff, Data_out_Borrow and Data_out_Overflow hold their last result until the next completion. They do not change during RUN.
- The counter is ceil(log2(WIDTH+1)) bits. No wrap occurs because the count stops at WIDTH.

## Timing
- Reset values: Busy=0, Done=0, Data_out_Diff=0, Data_out_Borrow=0, Data_out_Overflow=0, state=IDLE.
- Start sampled at edge E0. Busy=1 from E0 to E_WIDTH. Done=1 for the cycle after E_WIDTH, with Busy=0.
- Latency is WIDTH+1 cycles from the Start edge to the Done-high cycle.
- Throughput is one result per WIDTH+1 cycles with back-to-back Start.
- rst_n low at any time, including mid-RUN: outputs return to reset values immediately. The operation in flight is discarded and no Done is issued.
- rst_n deassertion is synchronized externally. The first edge after release may accept Start.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined: Data_out_Overflow is registered at completion as (A[MSB]≠B[MSB]) && (Diff[MSB]≠A[MSB]), using the captured operand MSBs, with Bin included in the result.
- Not defined: Data_out_Overflow is tied to 0 and no MSB capture logic is built. The port is always present.

## Test plan
- Reset, then A=0x5A, B=0x3C, Bin=0, Start: Done pulse exactly 9 cycles after the Start edge; Diff=0x1E, Borrow=0, Overflow=0.
- A=0x10, B=0x20, Bin=0: Diff=0xF0, Borrow=1, Overflow=0. Then A=0x00, B=0x00, Bin=1: Diff=0xFF, Borrow=1.
- With SERIAL_SUB_OVERFLOW_EN, A=0x80, B=0x01, Bin=0: Diff=0x7F, Borrow=0, Overflow=1. Without the macro, same stimulus gives Overflow=0.
- Start held high continuously with new operands at each accept: accepted only in the IDLE/DONE cycles, Done every 9 cycles, and each result matches the operands present on its accept edge. Operand changes during RUN have no effect.
- rst_n pulsed low at cycle 4 of RUN: Busy=0 and outputs=0 asynchronously, no Done. A new Start after release completes correctly (A=0xFF, B=0xFF → Diff=0x00, Borrow=0).
- Random sweep of 1000 operand/Bin triples against a reference model of A−B−Bin: Diff, Borrow and Overflow all match.
